// File: rtl/apb_arbiter.sv
// apb_arbiter: two-master/one-slave APB arbiter with round-robin grant.
// Optional ACCESS-phase timeout abort is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  APB_PCLK,
    input  logic                  APB_PRESETn,
    input  logic [ADDR_WIDTH-1:0] m0_paddr,
    input  logic [ADDR_WIDTH-1:0] m1_paddr,
    input  logic [DATA_WIDTH-1:0] m0_pdata,
    input  logic [DATA_WIDTH-1:0] m1_pdata,
    input  logic                  m0_psel,
    input  logic                  m1_psel,
    input  logic                  m0_penable,
    input  logic                  m1_penable,
    input  logic                  m0_pwrite,
    input  logic                  m1_pwrite,
    input  logic [3:0]            m0_pstb,
    input  logic [3:0]            m1_pstb,
    output logic [DATA_WIDTH-1:0] m0_prdata,
    output logic [DATA_WIDTH-1:0] m1_prdata,
    output logic                  m0_pready,
    output logic                  m1_pready,
    output logic                  m0_perr,
    output logic                  m1_perr,
    output logic [ADDR_WIDTH-1:0] s_paddr,
    output logic [DATA_WIDTH-1:0] s_pdata,
    output logic                  s_psel,
    output logic                  s_penable,
    output logic                  s_pwrite,
    output logic [3:0]            s_pstb,
    input  logic [DATA_WIDTH-1:0] s_prdata,
    input  logic                  s_pready,
    input  logic                  s_perr,
    output logic [1:0]            grant,
    output logic                  timeout_evt
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       last_q, last_d;
    logic       access, tmo, done, win0, r0, r1;
    logic       unused_penable;

    assign unused_penable = m0_penable ^ m1_penable;
    assign access = state_q == ACCESS;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // cnt_q counts stalled ACCESS cycles already seen, so the limit hits on the last one
    assign tmo   = access && !s_pready && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    assign cnt_d = (access && !s_pready && !tmo) ? cnt_q + 1'b1 : '0;
    always_ff @(posedge APB_PCLK or negedge APB_PRESETn) begin
        if (!APB_PRESETn) cnt_q <= '0;
        else              cnt_q <= cnt_d;
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign tmo = 1'b0;
`endif

    assign done    = access && (s_pready || tmo);
    // last_q = 1 means m1 owned the previous transfer, so m0 wins a tie
    assign win0    = m0_psel && (!m1_psel || last_q);
    assign grant_d = state_q == IDLE ? (win0 ? 2'b01 : m1_psel ? 2'b10 : 2'b00)
                   : done ? 2'b00 : grant_q;
    assign state_d = state_q == IDLE ? ((m0_psel || m1_psel) ? SETUP : IDLE)
                   : state_q == SETUP ? ACCESS
                   : done ? IDLE : ACCESS;
    assign last_d  = done ? grant_q[1] : last_q;

    always_ff @(posedge APB_PCLK or negedge APB_PRESETn) begin
        if (!APB_PRESETn) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign grant       = grant_q;
    assign timeout_evt = tmo;
    assign s_psel      = state_q != IDLE;
    assign s_penable   = access;
    assign s_paddr     = grant_q[0] ? m0_paddr  : grant_q[1] ? m1_paddr  : '0;
    assign s_pdata     = grant_q[0] ? m0_pdata  : grant_q[1] ? m1_pdata  : '0;
    assign s_pwrite    = grant_q[0] ? m0_pwrite : grant_q[1] ? m1_pwrite : 1'b0;
    assign s_pstb      = grant_q[0] ? m0_pstb   : grant_q[1] ? m1_pstb   : 4'b0;

    // an owner that dropped psel mid-transfer gets no response
    assign r0        = done && grant_q[0] && m0_psel;
    assign r1        = done && grant_q[1] && m1_psel;
    assign m0_pready = r0;
    assign m1_pready = r1;
    assign m0_perr   = r0 && (!s_pready || s_perr);
    assign m1_perr   = r1 && (!s_pready || s_perr);
    assign m0_prdata = (access && grant_q[0] && m0_psel) ? s_prdata : '0;
    assign m1_prdata = (access && grant_q[1] && m1_psel) ? s_prdata : '0;
endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter: directed self-checking bench for apb_arbiter.
module tb_apb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_paddr, m1_paddr, m0_pdata, m1_pdata, m0_prdata, m1_prdata;
    logic        m0_psel, m1_psel, m0_penable, m1_penable, m0_pwrite, m1_pwrite;
    logic [3:0]  m0_pstb, m1_pstb, s_pstb;
    logic        m0_pready, m1_pready, m0_perr, m1_perr;
    logic [31:0] s_paddr, s_pdata, s_prdata;
    logic        s_psel, s_penable, s_pwrite, s_pready, s_perr, timeout_evt;
    logic [1:0]  grant;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    apb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .APB_PCLK(clk), .APB_PRESETn(rst_n),
        .m0_paddr(m0_paddr), .m1_paddr(m1_paddr), .m0_pdata(m0_pdata), .m1_pdata(m1_pdata),
        .m0_psel(m0_psel), .m1_psel(m1_psel), .m0_penable(m0_penable), .m1_penable(m1_penable),
        .m0_pwrite(m0_pwrite), .m1_pwrite(m1_pwrite), .m0_pstb(m0_pstb), .m1_pstb(m1_pstb),
        .m0_prdata(m0_prdata), .m1_prdata(m1_prdata), .m0_pready(m0_pready), .m1_pready(m1_pready),
        .m0_perr(m0_perr), .m1_perr(m1_perr),
        .s_paddr(s_paddr), .s_pdata(s_pdata), .s_psel(s_psel), .s_penable(s_penable),
        .s_pwrite(s_pwrite), .s_pstb(s_pstb), .s_prdata(s_prdata), .s_pready(s_pready),
        .s_perr(s_perr), .grant(grant), .timeout_evt(timeout_evt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [1:0] gexp [12] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10,
                              2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};

    initial begin
        rst_n = 1'b0;
        m0_paddr = 32'h55; m1_paddr = 32'h0; m0_pdata = 32'h0; m1_pdata = 32'h0;
        m0_psel = 1'b1; m1_psel = 1'b0; m0_penable = 1'b0; m1_penable = 1'b0;
        m0_pwrite = 1'b1; m1_pwrite = 1'b0; m0_pstb = 4'hF; m1_pstb = 4'h0;
        s_prdata = 32'hCAFE; s_pready = 1'b1; s_perr = 1'b0;
        repeat (2) tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_psel", 32'(s_psel), 32'd0);
        check("rst_penable", 32'(s_penable), 32'd0);
        check("rst_paddr", s_paddr, 32'd0);
        check("rst_pwrite", 32'(s_pwrite), 32'd0);
        check("rst_m0_pready", 32'(m0_pready), 32'd0);
        check("rst_m0_prdata", m0_prdata, 32'd0);
        check("rst_tmo", 32'(timeout_evt), 32'd0);
        m0_psel = 1'b0; m0_pwrite = 1'b0; m0_pstb = 4'h0;
        rst_n = 1'b1;
        tick();

        // persistent contention from reset: m0 first, then strict alternation
        m0_paddr = 32'hA0; m1_paddr = 32'hB0;
        m0_psel = 1'b1; m1_psel = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            check($sformatf("cont_grant%0d", c), 32'(grant), 32'(gexp[c]));
            check($sformatf("cont_paddr%0d", c), s_paddr,
                  gexp[c] == 2'b01 ? 32'hA0 : gexp[c] == 2'b10 ? 32'hB0 : 32'h0);
            check($sformatf("cont_m0rdy%0d", c), 32'(m0_pready), 32'(c == 2 || c == 8));
            check($sformatf("cont_m1rdy%0d", c), 32'(m1_pready), 32'(c == 5 || c == 11));
            tick();
        end
        m0_psel = 1'b0; m1_psel = 1'b0;
        tick();

        // m0 write, zero-wait slave
        m0_paddr = 32'h0000_1000; m0_pdata = 32'hDEAD_BEEF; m0_pstb = 4'b0001;
        m0_pwrite = 1'b1; m0_psel = 1'b1; #1;
        check("wr_T_psel", 32'(s_psel), 32'd0);
        tick(); #1;
        check("wr_T1_psel", 32'(s_psel), 32'd1);
        check("wr_T1_penable", 32'(s_penable), 32'd0);
        check("wr_T1_grant", 32'(grant), 32'd1);
        check("wr_T1_paddr", s_paddr, 32'h0000_1000);
        check("wr_T1_pdata", s_pdata, 32'hDEAD_BEEF);
        check("wr_T1_pstb", 32'(s_pstb), 32'd1);
        check("wr_T1_pwrite", 32'(s_pwrite), 32'd1);
        check("wr_T1_m0rdy", 32'(m0_pready), 32'd0);
        tick(); #1;
        check("wr_T2_penable", 32'(s_penable), 32'd1);
        check("wr_T2_grant", 32'(grant), 32'd1);
        check("wr_T2_m0rdy", 32'(m0_pready), 32'd1);
        check("wr_T2_m0err", 32'(m0_perr), 32'd0);
        tick();
        m0_psel = 1'b0; #1;
        check("wr_T3_grant", 32'(grant), 32'd0);
        check("wr_T3_psel", 32'(s_psel), 32'd0);
        tick();

        // m1 read with three slave wait states
        m1_paddr = 32'h2000; m1_pwrite = 1'b0; m1_psel = 1'b1;
        s_pready = 1'b0; s_prdata = 32'h1234_5678;
        tick(); #1;
        check("rd_setup_grant", 32'(grant), 32'd2);
        check("rd_setup_prdata", m1_prdata, 32'd0);
        for (int w = 0; w < 3; w++) begin
            tick(); #1;
            check($sformatf("rd_wait%0d_rdy", w), 32'(m1_pready), 32'd0);
            check($sformatf("rd_wait%0d_en", w), 32'(s_penable), 32'd1);
        end
        tick();
        s_pready = 1'b1; #1;
        check("rd_m1rdy", 32'(m1_pready), 32'd1);
        check("rd_m1_prdata", m1_prdata, 32'h1234_5678);
        check("rd_m0_prdata", m0_prdata, 32'd0);
        check("rd_m0rdy", 32'(m0_pready), 32'd0);
        tick();
        m1_psel = 1'b0;
        tick();

        // slave error with both masters requesting (m0 wins: m1 went last)
        s_perr = 1'b1; m0_psel = 1'b1; m1_psel = 1'b1;
        tick(); tick(); #1;
        check("err_m0rdy", 32'(m0_pready), 32'd1);
        check("err_m0err", 32'(m0_perr), 32'd1);
        check("err_m1err", 32'(m1_perr), 32'd0);
        check("err_m1rdy", 32'(m1_pready), 32'd0);
        tick();
        m0_psel = 1'b0; m1_psel = 1'b0; s_perr = 1'b0; #1;
        check("err_idle_grant", 32'(grant), 32'd0);
        check("err_idle_psel", 32'(s_psel), 32'd0);
        tick();

        // asynchronous reset in ACCESS
        s_pready = 1'b0; m0_psel = 1'b1;
        tick(); tick(); #1;
        check("ar_access_en", 32'(s_penable), 32'd1);
        rst_n = 1'b0; #1;
        check("ar_psel", 32'(s_psel), 32'd0);
        check("ar_penable", 32'(s_penable), 32'd0);
        check("ar_grant", 32'(grant), 32'd0);
        check("ar_m0rdy", 32'(m0_pready), 32'd0);
        m0_psel = 1'b0; #1;
        rst_n = 1'b1;
        tick();
        s_pready = 1'b1; m1_psel = 1'b1;
        tick(); #1;
        check("ar_m1_grant", 32'(grant), 32'd2);
        tick(); #1;
        check("ar_m1rdy", 32'(m1_pready), 32'd1);
        tick();
        m1_psel = 1'b0;
        tick();

`ifdef APB_ARB_TIMEOUT_EN
        s_pready = 1'b0; m0_psel = 1'b1;
        tick();
        for (int k = 1; k <= 8; k++) begin
            tick(); #1;
            check($sformatf("to_evt%0d", k), 32'(timeout_evt), 32'(k == 8));
            check($sformatf("to_rdy%0d", k), 32'(m0_pready), 32'(k == 8));
            check($sformatf("to_err%0d", k), 32'(m0_perr), 32'(k == 8));
        end
        tick(); #1;
        check("to_after_psel", 32'(s_psel), 32'd0);
        check("to_after_evt", 32'(timeout_evt), 32'd0);
        m0_psel = 1'b0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
